// File: rtl/window_avg_decoder_pkg.sv
// Shared constants and types for the integrate-and-dump window decoder.
// SCALE and N_SAMPLES must match the integrator's per-sample weighting.
package window_avg_decoder_pkg;

   localparam int unsigned ACC_W     = 13;
   localparam int unsigned X_W       = 4;
   localparam int unsigned SCALE     = 25;
   localparam int unsigned N_SAMPLES = 4;
   localparam int unsigned DIV_D     = SCALE * N_SAMPLES;
   localparam int unsigned REM_W     = $clog2(DIV_D) + 1;
   localparam int unsigned AVG_MAX   = (2 ** X_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   // Clamp a full-width quotient to the largest representable average code.
   function automatic logic [X_W-1:0] saturate_avg(input logic [ACC_W-1:0] q);
      return (q > ACC_W'(AVG_MAX)) ? X_W'(AVG_MAX) : q[X_W-1:0];
   endfunction

endpackage

// File: rtl/seq_restoring_div.sv
// Bit-serial restoring divider by a constant: one quotient bit per cycle, W steps.
// done_c is high during the cycle whose edge performs the final step.
module seq_restoring_div #(
   parameter int unsigned W  = 13,
   parameter int unsigned D  = 100,
   parameter int unsigned RW = 8
) (
   input  logic          clock,
   input  logic          acc_rst2,
   input  logic          start_i,
   input  logic [W-1:0]  dividend_i,
   output logic          done_c,
   output logic [W-1:0]  quotient_o,
   output logic [RW-2:0] remainder_o
);

   localparam int unsigned CW = $clog2(W);

   logic          run_q, run_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  dvd_q, dvd_d;
   logic [W-1:0]  quo_q, quo_d;
   logic [RW-1:0] rem_q, rem_d;
   logic [RW:0]   rem_sh;
   logic          ge;

   always_comb begin
      run_d  = run_q;
      cnt_d  = cnt_q;
      dvd_d  = dvd_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      rem_sh = {rem_q, dvd_q[W-1]};
      ge     = (rem_sh >= (RW+1)'(D));
      done_c = run_q && (cnt_q == '0);
      if (start_i) begin
         run_d = 1'b1;
         cnt_d = CW'(W - 1);
         dvd_d = dividend_i;
         quo_d = '0;
         rem_d = '0;
      end else if (run_q) begin
         dvd_d = {dvd_q[W-2:0], 1'b0};
         quo_d = {quo_q[W-2:0], ge};
         rem_d = ge ? RW'(rem_sh - (RW+1)'(D)) : RW'(rem_sh);
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge acc_rst2) begin
      if (acc_rst2) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         dvd_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         dvd_q <= dvd_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
      end
   end

   // Remainder is always below D after a step, so the top bit is never set.
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q[RW-2:0];

endmodule

// File: rtl/window_avg_decoder.sv
// Recovers the average input code from a dumped window sum (y / (SCALE*N_SAMPLES))
// and presents it on a valid/ready handshake with saturation and overrun flags.
module window_avg_decoder
   import window_avg_decoder_pkg::*;
(
   input  logic             clock,
   input  logic             acc_rst2,
   input  logic [ACC_W-1:0] y_in,
   input  logic             sample,
   output logic [X_W-1:0]   avg,
   output logic [REM_W-2:0] rem_out,
   output logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun
);

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             start_c;
   logic             done_c;
   logic [ACC_W-1:0] quotient;

   seq_restoring_div #(
      .W  (ACC_W),
      .D  (DIV_D),
      .RW (REM_W)
   ) u_div (
      .clock       (clock),
      .acc_rst2    (acc_rst2),
      .start_i     (start_c),
      .dividend_i  (y_in),
      .done_c      (done_c),
      .quotient_o  (quotient),
      .remainder_o (rem_out)
   );

   // Handshake FSM; a HOLD-state transfer may coincide with a new capture.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      overrun_d   = overrun_q;
      start_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample) begin
               start_c = 1'b1;
               busy_d  = 1'b1;
               state_d = ST_DIV;
            end
         end
         ST_DIV: begin
            if (sample) begin
               overrun_d = 1'b1;
            end
            if (done_c) begin
               out_valid_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
               if (sample) begin
                  start_c = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ST_DIV;
               end
            end else if (sample) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge acc_rst2) begin
      if (acc_rst2) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   // Result fields come straight from the divider's registers, frozen once it stops.
   assign avg       = saturate_avg(quotient);
   assign sat       = (quotient > ACC_W'(AVG_MAX));
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_window_avg_decoder.sv
// Scoreboard bench for window_avg_decoder: expected results are queued at capture
// and compared (value and latency) when the output handshake completes.
module tb_window_avg_decoder;

   logic        clock;
   logic        acc_rst2;
   logic [12:0] y_in;
   logic        sample;
   logic [3:0]  avg;
   logic [6:0]  rem_out;
   logic        sat;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        overrun;

   typedef struct {
      int avg;
      int rem;
      int sat;
      int cap;
      bit chk_lat;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;

   window_avg_decoder dut (
      .clock     (clock),
      .acc_rst2  (acc_rst2),
      .y_in      (y_in),
      .sample    (sample),
      .avg       (avg),
      .rem_out   (rem_out),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic exp_t model(input int y, input int cap, input bit lat);
      exp_t e;
      int   q;
      q         = y / 100;
      e.rem     = y % 100;
      e.sat     = (q > 15) ? 1 : 0;
      e.avg     = (q > 15) ? 15 : q;
      e.cap     = cap;
      e.chk_lat = lat;
      return e;
   endfunction

   // Result monitor: pops on every completed output transfer.
   always @(negedge clock) begin
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("avg", int'(avg), e.avg);
            check("rem_out", int'(rem_out), e.rem);
            check("sat", int'(sat), e.sat);
            if (e.chk_lat) check("latency", cyc - e.cap, 13);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One-cycle sample strobe; expected result queued only when acceptance is expected.
   task automatic send(input int y, input bit push, input bit lat);
      tick();
      sample = 1'b1;
      y_in   = 13'(y);
      if (push) sb.push_back(model(y, cyc + 1, lat));
      tick();
      sample = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         check("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      if (!out_valid) check("valid_timeout", 0, 1);
   endtask

   task automatic do_reset();
      acc_rst2 = 1'b1;
      tick();
      tick();
      acc_rst2 = 1'b0;
   endtask

   initial begin
      acc_rst2  = 1'b1;
      sample    = 1'b0;
      y_in      = '0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_avg", int'(avg), 0);
      check("rst_rem", int'(rem_out), 0);
      check("rst_sat", int'(sat), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(overrun), 0);
      acc_rst2 = 1'b0;

      // Basic divisions, including zero and the saturating maximum.
      send(1000, 1'b1, 1'b1);
      check("busy_after_capture", int'(busy), 1);
      drain();
      check("valid_one_cycle", int'(out_valid), 0);
      check("busy_after_done", int'(busy), 0);
      send(1050, 1'b1, 1'b1);
      drain();
      send(0, 1'b1, 1'b1);
      drain();
      send(8191, 1'b1, 1'b1);
      drain();
      check("overrun_clean", int'(overrun), 0);

      // Backpressure: result held stable, dropped sample flags overrun.
      out_ready = 1'b0;
      send(500, 1'b1, 1'b0);
      wait_valid();
      for (int i = 0; i < 20; i++) begin
         check("hold_avg", int'(avg), 5);
         check("hold_valid", int'(out_valid), 1);
         sample = (i == 5);
         y_in   = 13'd123;
         tick();
      end
      sample = 1'b0;
      check("overrun_set", int'(overrun), 1);
      check("hold_busy", int'(busy), 0);
      out_ready = 1'b1;
      tick();
      check("valid_cleared", int'(out_valid), 0);
      check("sb_after_hold", sb.size(), 0);

      // Back-to-back: transfer and new capture in the same HOLD cycle.
      do_reset();
      check("overrun_reset", int'(overrun), 0);
      send(200, 1'b1, 1'b1);
      wait_valid();
      sample = 1'b1;
      y_in   = 13'd300;
      sb.push_back(model(300, cyc + 1, 1'b1));
      tick();
      sample = 1'b0;
      check("b2b_busy", int'(busy), 1);
      drain();
      check("b2b_overrun", int'(overrun), 0);

      // Asynchronous reset in the middle of a division.
      send(4000, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      #2;
      acc_rst2 = 1'b1;
      #1;
      check("mid_rst_avg", int'(avg), 0);
      check("mid_rst_rem", int'(rem_out), 0);
      check("mid_rst_sat", int'(sat), 0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_overrun", int'(overrun), 0);
      tick();
      acc_rst2 = 1'b0;
      send(700, 1'b1, 1'b1);
      drain();
      tick();
      check("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/window_avg_decoder.md
# window_avg_decoder

Consumer at the far end of the integrate-and-dump datapath. It captures each dumped accumulator window sum, y = 25·Σx over N_SAMPLES samples, and divides it back down to the average input code with a bit-serial restoring divider. The result is returned on a valid/ready output handshake. It sits after the integrator and reconstructs the 4-bit x value that the integrator encoded.

## Interface
- ACC_W, 13, width of the incoming window sum
- X_W, 4, width of the recovered average code
- SCALE, 25, per-sample weight applied upstream
- N_SAMPLES, 4, samples per integration window; divisor D = SCALE·N_SAMPLES = 100
- clock  input  1  rising-edge clock
- acc_rst2  input  1  reset, asynchronous, active-high
- y_in  input  ACC_W  window sum from the integrator
- sample  input  1  one-cycle strobe: y_in is valid this cycle
- avg  output  X_W  recovered average, saturated to 2^X_W−1
- rem_out  output  7  remainder of y_in mod D, bounded by D−1 = 99
- sat  output  1  quotient exceeded 2^X_W−1
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- busy  output  1  divider running
- overrun  output  1  sticky: a sample was dropped

## Operation
- States: IDLE, DIV, HOLD.
- IDLE, sample=1: latch y_in into dividend, clear partial remainder, set bit counter to ACC_W−1, go to DIV. busy=1.
- DIV: one restoring step per cycle.
  - Shift remainder left by 1 and bring in the dividend MSB.
  - If remainder ≥ D, subtract D and set the quotient bit; otherwise clear it.
  - After ACC_W steps, go to HOLD.
- Entering HOLD:
  - If quotient > 2^X_W−1: avg = 2^X_W−1, sat=1. Otherwise avg = quotient[X_W−1:0], sat=0.
  - rem_out = final remainder. out_valid=1, busy=0.
- HOLD: outputs stay stable until out_valid & out_ready, then go to IDLE and clear out_valid.
- HOLD with out_ready=1 and sample=1 in the same cycle: the transfer completes and the new sample is captured, going directly to DIV. No bubble, no overrun.
- sample=1 in DIV, or in HOLD with out_ready=0: the sample is dropped and overrun is set. overrun clears only on reset.
- Arithmetic: the remainder register is 8 bits wide, which holds up to 2·99+1 = 199. The quotient register is ACC_W bits. Maximum quotient is 8191/100 = 81.
- acc_rst2 asserted at any time, including mid-DIV or in HOLD: immediately go to IDLE. All outputs go to 0: avg, rem_out, sat, out_valid, busy, overrun. The in-flight result is discarded.

## Timing
- Capture edge E0. Division steps occur on E1..E13. out_valid=1 after edge E13, so latency is ACC_W cycles from the capture edge.
- Maximum throughput: one result every ACC_W+1 cycles with out_ready held high. Back-to-back operation uses the HOLD+sample rule above.
- busy is high from after E0 through E13. It is low in HOLD.
- Reset is asynchronous assert. Deassertion is sampled on the next rising edge, with first capture possible on that edge.
- Outputs are registered, with no combinational path from inputs to outputs. The exception is that out_ready only affects the next state.

## Structure
- Shared package holds:
  - the state enum (IDLE/DIV/HOLD)
  - SCALE and N_SAMPLES, shared with the integrator's multiplier constant
  - the derived divisor constant D
  - the remainder width, computed as clog2(D)+1
- Natural sub-module: seq_restoring_div, a generic bit-serial divider.
  - Ports: start, dividend, done, quotient, remainder. Parameterised on width and divisor.
  - window_avg_decoder wraps it with the handshake, saturation, and overrun logic.

## Test plan
- y_in=1000 (four samples of x=10), out_ready=1 → after 13 cycles avg=10, rem_out=0, sat=0, one-cycle out_valid.
- y_in=1050 → avg=10, rem_out=50. Then y_in=0 → avg=0, rem_out=0.
- y_in=8191 → avg=15, sat=1, rem_out=91.
- out_ready=0 for 20 cycles after result y_in=500 (avg=5): avg stays stable. A second sample during HOLD sets overrun=1 and the result stays 5. Raising out_ready clears out_valid.
- HOLD with out_ready=1 and sample=1 (y_in=300) in the same cycle → first result transfers, the second yields avg=3 exactly 13 cycles later, overrun stays 0.
- acc_rst2 pulsed at DIV step 6 → all outputs are 0 immediately. A following sample of y_in=700 yields avg=7 with no residue from the aborted division.
